// File: rtl/boot_loader.sv
// Streams a little-endian boot image (count, entry PC, payload) into instruction memory, then releases the core.
// Optional trailer checksum byte when BOOT_CHECKSUM_EN is defined.
module boot_loader #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_reset,
  output logic [63:0]       boot_pc,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_COUNT, S_ENTRY, S_PAYLOAD, S_CHECK, S_FIN, S_FAIL, S_DONE, S_ERROR
  } state_t;

`ifdef BOOT_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHECK;
  localparam logic TAIL_RDY = 1'b1;
`else
  localparam state_t S_TAIL = S_FIN;
  localparam logic TAIL_RDY = 1'b0;
`endif

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  state_t          state;
  logic [63:0]     shreg;
  logic [63:0]     sh_next;
  logic [3:0]      byte_idx;
  logic [ADDR_W:0] count_q;
  logic [ADDR_W:0] word_idx;
  logic            take;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]      xsum;
`endif

  assign take = in_valid && in_ready;
  // Bytes enter at the top so a completed field sits LSB-first in the upper bits.
  assign sh_next = {in_data, shreg[63:8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_COUNT;
      shreg     <= '0;
      byte_idx  <= '0;
      count_q   <= '0;
      word_idx  <= '0;
      in_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_reset <= 1'b1;
      boot_pc   <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      xsum      <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (take) begin
        shreg <= sh_next;
`ifdef BOOT_CHECKSUM_EN
        xsum  <= xsum ^ in_data;
`endif
      end
      case (state)
        S_COUNT: begin
          in_ready <= 1'b1;
          if (take) begin
            byte_idx <= byte_idx + 4'd1;
            if (byte_idx == 4'd3) begin
              byte_idx <= '0;
              if (sh_next[63:32] > DEPTH_L) begin
                state    <= S_ERROR;
                in_ready <= 1'b0;
                error    <= 1'b1;
              end else begin
                count_q <= sh_next[32 +: ADDR_W+1];
                state   <= S_ENTRY;
              end
            end
          end
        end
        S_ENTRY: begin
          in_ready <= 1'b1;
          if (take) begin
            byte_idx <= byte_idx + 4'd1;
            if (byte_idx == 4'd7) begin
              byte_idx <= '0;
              if (sh_next[1:0] != 2'b00) begin
                state    <= S_ERROR;
                in_ready <= 1'b0;
                error    <= 1'b1;
              end else begin
                boot_pc <= sh_next;
                if (count_q == '0) begin
                  state    <= S_TAIL;
                  in_ready <= TAIL_RDY;
                end else begin
                  state <= S_PAYLOAD;
                end
              end
            end
          end
        end
        S_PAYLOAD: begin
          in_ready <= 1'b1;
          if (take) begin
            byte_idx <= byte_idx + 4'd1;
            if (byte_idx[1:0] == 2'd3) begin
              byte_idx <= '0;
              wr_en    <= 1'b1;
              wr_addr  <= word_idx[ADDR_W-1:0];
              wr_data  <= sh_next[63:32];
              word_idx <= word_idx + 1'b1;
              if (word_idx + 1'b1 == count_q) begin
                state    <= S_TAIL;
                in_ready <= TAIL_RDY;
              end
            end
          end
        end
`ifdef BOOT_CHECKSUM_EN
        S_CHECK: begin
          in_ready <= 1'b1;
          if (take) begin
            in_ready <= 1'b0;
            state    <= (in_data == xsum) ? S_FIN : S_FAIL;
          end
        end
        S_FAIL: begin
          state   <= S_ERROR;
          error   <= 1'b1;
          boot_pc <= '0;
        end
`endif
        // One idle edge lets the final write pulse finish before the core is released.
        S_FIN: begin
          state     <= S_DONE;
          done      <= 1'b1;
          cpu_reset <= 1'b0;
        end
        default: in_ready <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: scoreboarded memory writes plus header/status checks.
module tb_boot_loader;

  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_reset;
  logic [63:0]       boot_pc;
  logic              done;
  logic              error;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int wr_cnt = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img_words[$];

  boot_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_reset(cpu_reset), .boot_pc(boot_pc), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && wr_en) begin
      wr_t e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 64'(wr_addr), 64'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    wr_cnt = 0;
    exp_q.delete();
  endtask

  // Sends one byte; returns once it has been accepted (or a bounded wait expires).
  task automatic send(input logic [7:0] b, input bit gap);
    bit ok;
    if (gap) begin
      in_valid = 1'b0;
      step();
    end
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      ok = in_ready;
      step();
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
  endtask

  // Sends the first nbytes of an image (-1 = whole image incl. optional trailer).
  task automatic send_image(input logic [31:0] n, input logic [63:0] entry,
                            input bit gap, input bit push, input int nbytes, input bit bad_sum);
    logic [7:0] bytes[$];
    logic [7:0] x;
    for (int i = 0; i < 4; i++) bytes.push_back(n[8*i +: 8]);
    for (int i = 0; i < 8; i++) bytes.push_back(entry[8*i +: 8]);
    for (int k = 0; k < img_words.size(); k++) begin
      for (int i = 0; i < 4; i++) bytes.push_back(img_words[k][8*i +: 8]);
      if (push) exp_q.push_back('{addr: ADDR_W'(k), data: img_words[k]});
    end
`ifdef BOOT_CHECKSUM_EN
    x = '0;
    foreach (bytes[i]) x = x ^ bytes[i];
    bytes.push_back(bad_sum ? ~x : x);
`else
    x = {7'd0, bad_sum};
`endif
    for (int i = 0; i < bytes.size() && (nbytes < 0 || i < nbytes); i++) send(bytes[i], gap);
    in_valid = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [63:0] pc, input int writes);
    check({tag, "_pre_done"}, 64'(done), 64'd0);
    check({tag, "_pre_cpu_reset"}, 64'(cpu_reset), 64'd1);
    step();
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_boot_pc"}, boot_pc, pc);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_writes"}, 64'(wr_cnt), 64'(writes));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_boot_pc", boot_pc, 64'd0);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    reset = 1'b0;
    check("rdy_before_edge", 64'(in_ready), 64'd0);
    step();
    check("rdy_after_edge", 64'(in_ready), 64'd1);

    // N=2 at full rate
    img_words = '{32'hD280_0013, 32'h1400_0000};
    send_image(32'd2, 64'h8, 1'b0, 1'b1, -1, 1'b0);
`ifndef BOOT_CHECKSUM_EN
    check("full_last_wr_before_release", 64'(wr_en), 64'd1);
`endif
    expect_done("full", 64'h8, 2);

    // Same image, valid toggled every other cycle
    do_reset();
    send_image(32'd2, 64'h8, 1'b1, 1'b1, -1, 1'b0);
    expect_done("gap", 64'h8, 2);

    // Oversize count
    do_reset();
    img_words = {};
    send_image(32'(DEPTH + 1), 64'h0, 1'b0, 1'b0, 4, 1'b0);
    check("big_error", 64'(error), 64'd1);
    check("big_in_ready", 64'(in_ready), 64'd0);
    check("big_cpu_reset", 64'(cpu_reset), 64'd1);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    repeat (6) step();
    in_valid = 1'b0;
    check("big_still_error", 64'(error), 64'd1);
    check("big_done", 64'(done), 64'd0);
    check("big_writes", 64'(wr_cnt), 64'd0);

    // Misaligned entry
    do_reset();
    send_image(32'd1, 64'h6, 1'b0, 1'b0, 12, 1'b0);
    check("mis_error", 64'(error), 64'd1);
    check("mis_boot_pc", boot_pc, 64'd0);
    check("mis_in_ready", 64'(in_ready), 64'd0);
    check("mis_cpu_reset", 64'(cpu_reset), 64'd1);

    // Empty image
    do_reset();
    img_words = {};
    send_image(32'd0, 64'h100, 1'b0, 1'b1, -1, 1'b0);
    expect_done("empty", 64'h100, 0);

    // Reset mid-payload, then a fresh one-word image
    do_reset();
    img_words = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    send_image(32'd3, 64'h20, 1'b0, 1'b0, 14, 1'b0);
    do_reset();
    step();
    check("mid_rdy", 64'(in_ready), 64'd1);
    img_words = '{32'hAABB_CCDD};
    send_image(32'd1, 64'h40, 1'b0, 1'b1, -1, 1'b0);
    expect_done("restart", 64'h40, 1);

`ifdef BOOT_CHECKSUM_EN
    // Wrong trailer
    do_reset();
    img_words = '{32'h0BAD_F00D};
    send_image(32'd1, 64'h80, 1'b0, 1'b1, -1, 1'b1);
    check("sum_pre_error", 64'(error), 64'd0);
    step();
    check("sum_error", 64'(error), 64'd1);
    check("sum_done", 64'(done), 64'd0);
    check("sum_cpu_reset", 64'(cpu_reset), 64'd1);
    check("sum_boot_pc", boot_pc, 64'd0);
    check("sum_writes", 64'(wr_cnt), 64'd1);
`endif

    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
# boot_loader

Streams a program image into instruction memory after reset and holds the CPU core in reset until the image is fully written. Accepts a little-endian byte stream over a valid/ready handshake, parses a header (word count, entry PC), writes 32-bit instruction words into the instruction memory write port, then releases the core with the entry PC. It sits between the host/debug byte link and the instruction memory and CPU core, as the writer side of the memory the core fetches from.

## Interface
- `DEPTH_WORDS`, default 1024: instruction memory capacity in 32-bit words.
- `ADDR_W`, default 10: word-address width; `2**ADDR_W >= DEPTH_WORDS`.
- `clk` input, 1 bit: the single clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: byte on `in_data` is valid.
- `in_data` input, 8 bits: stream byte.
- `in_ready` output, 1 bit: loader accepts a byte this cycle.
- `wr_en` output, 1 bit: instruction memory write strobe, one-cycle pulse.
- `wr_addr` output, `ADDR_W` bits: word index.
- `wr_data` output, 32 bits: instruction word.
- `cpu_reset` output, 1 bit: holds the core in reset while high.
- `boot_pc` output, 64 bits: entry PC for the core, stable while `done`.
- `done` output, 1 bit: image loaded, core released.
- `error` output, 1 bit: malformed image; the core stays in reset.

## Operation
- A byte transfers on a rising edge where `in_valid && in_ready`. `in_data` is ignored otherwise.
- Image format, all fields little-endian (the first byte of a field is bits [7:0]):
  - COUNT: 4 bytes, number of words N.
  - ENTRY: 8 bytes, entry PC.
  - PAYLOAD: N×4 bytes.
  - CHECK: 1 checksum byte, only when the macro is defined (see Configuration).
- FSM states: COUNT → ENTRY → PAYLOAD → (CHECK) → DONE, plus ERROR.
  - COUNT: after 4 bytes, if N > `DEPTH_WORDS` → ERROR, else → ENTRY.
  - ENTRY: after 8 bytes, if entry[1:0] ≠ 0 → ERROR. Otherwise → PAYLOAD, or directly to CHECK/DONE when N = 0.
  - PAYLOAD: assembles each group of 4 bytes into one word. Word k is written to `wr_addr` = k, for k = 0..N-1. After word N-1 → CHECK/DONE.
  - DONE and ERROR are terminal until `reset`.
- `in_ready` = 1 in COUNT, ENTRY, PAYLOAD and CHECK; 0 in DONE and ERROR. In ERROR, further bytes stall at the source.
- `cpu_reset` = 1 in every state except DONE.
- `boot_pc` = the entry field once ENTRY completes. It is 0 in ERROR.
- Reset mid-load: the FSM returns to COUNT and all counters clear. Words already written to memory are not erased; the next image overwrites them.

## Timing
- Reset values:
  - `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `boot_pc`=0.
  - `cpu_reset`=1, `done`=0, `error`=0.
  - `in_ready` rises on the first clock edge after `reset` deasserts.
- All outputs are registered.
- `wr_en`, `wr_addr` and `wr_data` are valid in the cycle after the 4th byte of a word is accepted. The pulse lasts exactly 1 cycle.
- Back-to-back bytes at full rate are accepted with no bubbles. The fastest write rate is one word every 4 cycles.
- Let edge E be the edge that accepts the final image byte (last payload byte, last ENTRY byte when N=0, or the checksum byte). Then:
  - `done`=1 and `cpu_reset`=0 after edge E+1.
  - On error, `error`=1 after edge E+1.
  - The final `wr_en` pulse therefore always completes before `cpu_reset` falls.
- A header error (oversize N, misaligned entry) sets `error` after the edge following the offending field's last byte. `in_ready` drops on that same edge.
- `done` and `error` are never both 1.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - The CHECK state exists and consumes one trailer byte.
  - The trailer must equal the XOR of every preceding image byte (header and payload). Mismatch → ERROR, and `cpu_reset` stays 1.
  - Written words are not rolled back.
- Not defined:
  - There is no CHECK state and no trailer byte.
  - The image ends at the last payload byte (or the last ENTRY byte when N=0).

## Test plan
- N=2, entry=0x8, payload bytes 13 00 80 D2 then 00 00 00 14, full-rate valid → writes addr0=0xD2800013 and addr1=0x14000000, one `wr_en` pulse each. `done`=1, `cpu_reset`=0, `boot_pc`=0x8.
- Same image with `in_valid` toggled every other cycle → identical writes and final state, with no duplicated or dropped bytes.
- N=`DEPTH_WORDS`+1 → `error`=1 after the 4th byte, `in_ready`=0, no `wr_en` pulses, `cpu_reset`=1.
- Entry=0x6 → `error`=1 after the 12th byte, `boot_pc`=0.
- N=0 → `done`=1 two edges after the last ENTRY byte, with no writes.
- `reset` pulsed after 2 payload bytes, then a full image with N=1 is sent → the first pulse writes addr0 with the new word; `done`=1. With `BOOT_CHECKSUM_EN`, a wrong trailer gives `error`=1 and a correct trailer gives `done`=1.
